// File: rtl/cic_frame_sched.sv
// cic_frame_sched: collects one CIC sample per channel and streams them as a frame (frame_cnt gated by CIC_FRAME_SCHED_FRAME_CNT_EN)
module cic_frame_sched #(
  parameter int N_CH = 4,
  parameter int DW   = 32,
  parameter int CH_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_valid,
  output logic [DW-1:0]      out_data,
  output logic [CH_W-1:0]    out_ch,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_CH-1:0]    ovf,
  input  logic               ovf_clr,
  output logic [15:0]        frame_cnt
);
  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;
  state_t state_q, state_d;
  logic [N_CH-1:0] full_q, full_d, ovf_q, ovf_d, clr, cap;
  logic [N_CH-1:0][DW-1:0] hold_q, hold_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d, nxt_ch;
  logic out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic hs, last_hs;
  assign hs = out_valid_q & out_ready;
  assign last_hs = hs & (out_ch_q == CH_W'(N_CH - 1));
  assign nxt_ch = out_ch_q + 1'b1;
  // sequencing: fill, emit channel 0 on the fill edge, then one channel per handshake
  always_comb begin
    state_d = state_q;
    out_data_d = out_data_q;
    out_ch_d = out_ch_q;
    out_last_d = out_last_q;
    out_valid_d = out_valid_q;
    clr = '0;
    case (state_q)
      IDLE: state_d = enable ? COLLECT : IDLE;
      COLLECT: begin
        if (!enable) state_d = IDLE;
        else if (&full_q) begin
          state_d = SEND;
          out_data_d = hold_q[0];
          out_ch_d = '0;
          clr[0] = 1'b1;
          out_valid_d = 1'b1;
          out_last_d = (N_CH == 1);
        end
      end
      SEND: begin
        if (last_hs) begin
          out_valid_d = 1'b0;
          out_last_d = 1'b0;
          state_d = enable ? COLLECT : IDLE;
        end else if (hs) begin
          out_data_d = hold_q[nxt_ch];
          out_ch_d = nxt_ch;
          clr[nxt_ch] = 1'b1;
          out_last_d = (nxt_ch == CH_W'(N_CH - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // capture and overwrite tracking; a load on the same edge consumes the old sample, so no overflow
  always_comb begin
    cap = (state_q != IDLE) ? in_valid : '0;
    for (int k = 0; k < N_CH; k++) hold_d[k] = cap[k] ? in_data[k*DW +: DW] : hold_q[k];
    full_d = (state_q == IDLE) ? '0 : ((full_q & ~clr) | cap);
    ovf_d = (ovf_clr ? '0 : ovf_q) | (cap & full_q & ~clr);
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      full_q <= '0;
      hold_q <= '0;
      ovf_q <= '0;
      out_data_q <= '0;
      out_ch_q <= '0;
      out_last_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q <= full_d;
      hold_q <= hold_d;
      ovf_q <= ovf_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      out_last_q <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
  assign out_last = out_last_q;
  assign out_valid = out_valid_q;
  assign ovf = ovf_q;
`ifdef CIC_FRAME_SCHED_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  // completed-frame count, bumped on the final beat's handshake
  always_comb frame_cnt_d = frame_cnt_q + 16'(last_hs);
  // frame counter register
  always_ff @(posedge clk) frame_cnt_q <= rst ? 16'd0 : frame_cnt_d;
  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif
endmodule
